// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: accepts one request, drives the ALU operand/opcode
// registers, waits an opcode-dependent latency, then presents the 64-bit result.
module alu_op_sequencer #(
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 8,
    parameter int BASIC_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_A,
    output logic [31:0] alu_Y,
    output logic [31:0] alu_B,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_C,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                             ((MUL_LAT > BASIC_LAT) ? MUL_LAT : BASIC_LAT) :
                             ((DIV_LAT > BASIC_LAT) ? DIV_LAT : BASIC_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_pend_q, err_pend_d;
    logic               load_ops;
    logic               capture;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic op_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [CNT_W-1:0] op_cnt_init(input logic [4:0] op);
        case (op)
            OP_MUL:  return CNT_W'(MUL_LAT - 1);
            OP_DIV:  return CNT_W'(DIV_LAT - 1);
            default: return CNT_W'(BASIC_LAT - 1);
        endcase
    endfunction

    // Error requests still pass through one EXEC cycle so every response,
    // legal or not, appears at least one edge after the accept edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        load_ops   = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    load_ops = 1'b1;
                    state_d  = EXEC;
                    if (!op_legal(req_opcode) || (req_opcode == OP_DIV && req_b == '0)) begin
                        err_pend_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        err_pend_d = 1'b0;
                        cnt_d      = op_cnt_init(req_opcode);
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign alu_Y = alu_A;

    // Handshake flags are registered from the next state so req_ready stays
    // low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
            rsp_lo     <= '0;
            rsp_hi     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            req_ready  <= (state_d == IDLE);
            rsp_valid  <= (state_d == RESP);
            if (load_ops) begin
                alu_A      <= req_a;
                alu_B      <= req_b;
                alu_opcode <= req_opcode;
            end
            if (capture) begin
                if (err_pend_q) begin
                    rsp_lo  <= '0;
                    rsp_hi  <= '0;
                    rsp_err <= 1'b1;
                end else begin
                    rsp_lo  <= alu_C[31:0];
                    rsp_hi  <= op_wide(alu_opcode) ? alu_C[63:32] : '0;
                    rsp_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench for alu_op_sequencer with a behavioural ALU and
// a response reference model derived from the opcode/latency rules.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_A, alu_Y, alu_B;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_C;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] cur_lo, cur_hi, cur_a, cur_b;
    logic        cur_err;
    logic [4:0]  cur_op;
    int          cur_lat;

    logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                   5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

    alu_op_sequencer #(.MUL_LAT(4), .DIV_LAT(8), .BASIC_LAT(1)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_A(alu_A), .alu_Y(alu_Y), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_C(alu_C),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; upper word is junk for narrow ops so the sequencer must zero it.
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [31:0] r;
        s = int'(b[4:0]);
        case (op)
            5'd3:    r = a + b;
            5'd4:    r = a - b;
            5'd5:    r = a & b;
            5'd6:    r = a | b;
            5'd7:    r = a >> s;
            5'd8:    r = $unsigned($signed(a) >>> s);
            5'd9:    r = a << s;
            5'd10:   r = (a >> s) | (a << (32 - s));
            5'd11:   r = (a << s) | (a >> (32 - s));
            5'd17:   r = -a;
            5'd18:   r = ~a;
            default: r = b;
        endcase
        if (op == 5'd15) return {32'b0, a} * {32'b0, b};
        if (op == 5'd16) return (b != 0) ? {a % b, a / b} : 64'hDEAD_BEEF_DEAD_BEEF;
        return {~a ^ 32'h5A5A_0000, r};
    endfunction

    assign alu_C = alu_model(alu_opcode, alu_A, alu_B);

    task automatic ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] lo, output logic [31:0] hi, output logic err, output int lat);
        logic [63:0] c;
        logic legal;
        legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
        if (!legal || (op == 5'd16 && b == 0)) begin
            lo = 0; hi = 0; err = 1'b1; lat = 1;
        end else begin
            c   = alu_model(op, a, b);
            lo  = c[31:0];
            hi  = (op == 5'd15 || op == 5'd16) ? c[63:32] : 32'h0;
            err = 1'b0;
            lat = (op == 5'd15) ? 4 : (op == 5'd16) ? 8 : 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents a request and returns at the negedge after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        ref_model(op, a, b, cur_lo, cur_hi, cur_err, cur_lat);
        cur_op = op; cur_a = a; cur_b = b;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic complete(input int hold);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            chk("alu_opcode_exec", 64'(alu_opcode), 64'(cur_op));
            chk("alu_ab_exec", {alu_A, alu_B}, {cur_a, cur_b});
            chk("alu_y_exec", 64'(alu_Y), 64'(cur_a));
            chk("ready_low_exec", 64'(req_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(cur_lat));
        chk("rsp_data", {rsp_hi, rsp_lo}, {cur_hi, cur_lo});
        chk("rsp_err", 64'(rsp_err), 64'(cur_err));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", {rsp_hi, rsp_lo}, {cur_hi, cur_lo});
            chk("hold_err", 64'(rsp_err), 64'(cur_err));
            chk("hold_alu", {alu_A, alu_B}, {cur_a, cur_b});
            chk("hold_opcode", 64'(alu_opcode), 64'(cur_op));
            chk("ready_low_resp", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("valid_drop", 64'(rsp_valid), 64'd0);
        chk("ready_back", 64'(req_ready), 64'd1);
        chk("idle_not_busy", 64'(busy), 64'd0);
        chk("rsp_retained", {rsp_hi, rsp_lo}, {cur_hi, cur_lo});
    endtask

    initial begin
        logic [63:0] got [4];
        int          nrsp;
        int          acc2;
        logic        seen;
        logic [4:0]  op;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu", {alu_A, alu_B}, 64'd0);
        chk("rst_opcode", 64'(alu_opcode), 64'd0);
        chk("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        clr = 1'b1;
        #1 chk("ready_low_at_release", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);

        // Add 5+7
        issue(5'b00011, 32'd5, 32'd7);
        complete(0);
        chk("add_lo", 64'(rsp_lo), 64'd12);
        chk("add_hi", 64'(rsp_hi), 64'd0);

        // Mul 0x10000 * 0x10000
        issue(5'b01111, 32'h0001_0000, 32'h0001_0000);
        complete(0);
        chk("mul_result", {rsp_hi, rsp_lo}, 64'h0000_0001_0000_0000);

        // Divide by zero and illegal opcode
        issue(5'b10000, 32'd100, 32'd0);
        complete(0);
        chk("div0_err", 64'(rsp_err), 64'd1);
        issue(5'b11111, 32'd100, 32'd3);
        complete(1);
        chk("illegal_err", {31'b0, rsp_err, rsp_lo}, {31'b0, 1'b1, 32'd0});

        // Backpressure with a second request held pending
        issue(5'b00100, 32'd10, 32'd3);
        req_valid = 1'b1; req_opcode = 5'b00110; req_a = 32'h0000_1200; req_b = 32'h0000_0034;
        complete(5);
        chk("sub_lo", 64'(rsp_lo), 64'd7);
        chk("pending_ignored", 64'(alu_opcode), 64'b00100);
        issue(5'b00110, 32'h0000_1200, 32'h0000_0034);
        complete(0);
        chk("or_lo", 64'(rsp_lo), 64'h1234);

        // Back-to-back with req_valid and rsp_ready held high
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_opcode = 5'b10000; req_a = 32'd100; req_b = 32'd7;
        @(negedge clk);
        req_opcode = 5'b00101; req_a = 32'h0000_F0F0; req_b = 32'h0000_0FF0;
        acc2 = -1;
        nrsp = 0;
        for (int k = 1; k <= 30; k++) begin
            if (acc2 < 0 && req_ready) acc2 = k;
            @(negedge clk);
            if (acc2 == k) req_valid = 1'b0;
            if (rsp_valid && nrsp < 4) begin
                got[nrsp] = {rsp_hi, rsp_lo};
                nrsp++;
            end
        end
        rsp_ready = 1'b0;
        chk("b2b_accept_edge", 64'(acc2), 64'd10);
        chk("b2b_count", 64'(nrsp), 64'd2);
        chk("b2b_div", got[0], {32'd2, 32'd14});
        chk("b2b_and", got[1], 64'h0000_00F0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 12)];
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) b = b & 32'h0000_00FF;
            issue(op, a, b);
            complete($urandom_range(0, 2));
        end

        // Async reset in the middle of a Div
        issue(5'b10000, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_alu", {alu_A, alu_B}, 64'd0);
        chk("midrst_alu_y", 64'(alu_Y), 64'd0);
        chk("midrst_opcode", 64'(alu_opcode), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        #1 chk("midrst_ready_release", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("midrst_ready_next", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
